// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and decode helpers for the fetch front end
package fetch_pkg;
  localparam int ADDR_W_DEF = 12;
  localparam int OPC_HI     = 31;
  localparam int OPC_LO     = 27;
  localparam int JT_HI      = 26;
  localparam int JT_LO      = 0;
  localparam logic [4:0] OPC_J = 5'b00001;
  localparam int BUF_DEPTH  = 2;
  localparam int CNT_W      = $clog2(BUF_DEPTH + 1);

  function automatic logic is_jump(input logic [31:0] instr);
    return instr[OPC_HI:OPC_LO] == OPC_J;
  endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch-to-decode handshake bundle
interface fetch_stage_if #(parameter int ADDR_W = fetch_pkg::ADDR_W_DEF);
  logic              dec_valid;
  logic              dec_ready;
  logic [31:0]       dec_instr;
  logic [ADDR_W-1:0] dec_pc;
  logic [ADDR_W-1:0] dec_pc_plus1;

  modport master (output dec_valid, dec_instr, dec_pc, dec_pc_plus1, input dec_ready);
  modport slave  (input dec_valid, dec_instr, dec_pc, dec_pc_plus1, output dec_ready);
endinterface

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - 2-entry instruction FIFO with registered head and flush
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [31:0]       push_instr_i,
  input  logic [ADDR_W-1:0] push_pc_i,
  input  logic              pop_i,
  output logic [31:0]       head_instr_o,
  output logic [ADDR_W-1:0] head_pc_o,
  output logic [CNT_W-1:0]  count_o
);
  logic [31:0]       head_instr_q, head_instr_d, tail_instr_q, tail_instr_d;
  logic [ADDR_W-1:0] head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // pop is only asserted with a non-empty buffer; push is never issued into a full one
  always_comb begin
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    tail_instr_d = tail_instr_q;
    tail_pc_d    = tail_pc_q;
    count_d      = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (count_q == '0) begin
            head_instr_d = push_instr_i;
            head_pc_d    = push_pc_i;
          end else begin
            tail_instr_d = push_instr_i;
            tail_pc_d    = push_pc_i;
          end
          count_d = count_q + CNT_W'(1);
        end
        2'b01: begin
          head_instr_d = tail_instr_q;
          head_pc_d    = tail_pc_q;
          count_d      = count_q - CNT_W'(1);
        end
        2'b11: begin
          if (count_q == CNT_W'(1)) begin
            head_instr_d = push_instr_i;
            head_pc_d    = push_pc_i;
          end else begin
            head_instr_d = tail_instr_q;
            head_pc_d    = tail_pc_q;
            tail_instr_d = push_instr_i;
            tail_pc_d    = push_pc_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_instr_q <= '0;
      head_pc_q    <= '0;
      tail_instr_q <= '0;
      tail_pc_q    <= '0;
      count_q      <= '0;
    end else begin
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      tail_instr_q <= tail_instr_d;
      tail_pc_q    <= tail_pc_d;
      count_q      <= count_d;
    end
  end

  assign head_instr_o = head_instr_q;
  assign head_pc_o    = head_pc_q;
  assign count_o      = count_q;
endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, imem issue, redirect and halt logic; FETCH_HALT_DETECT_EN enables self-loop halt
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] address_imem,
  input  logic [31:0]       q_imem,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  fetch_stage_if.master     dec,
  output logic              halted
);
  logic [ADDR_W-1:0] pc_q, pc_d, inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d, tag_q, tag_d, epoch_q, epoch_d;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occupancy;
  logic              accept, issue, push, flush, halt_w;

  assign dec.dec_valid    = (count != '0);
  assign dec.dec_pc_plus1 = dec.dec_pc + ADDR_W'(1);
  assign accept           = dec.dec_valid && dec.dec_ready;
  assign address_imem     = pc_q;

  // words held after this cycle plus the one still in the imem pipe must fit the buffer
  assign occupancy = {1'b0, count} - {{CNT_W{1'b0}}, accept} + {{CNT_W{1'b0}}, inflight_q};
  assign flush     = redirect_valid && !halt_w;
  assign issue     = !halt_w && !redirect_valid && (occupancy < (CNT_W+1)'(BUF_DEPTH));
  assign push      = inflight_q && (tag_q == epoch_q) && !flush && !halt_w;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    tag_d         = tag_q;
    epoch_d       = epoch_q;
    if (issue) begin
      pc_d          = pc_q + ADDR_W'(1);
      inflight_pc_d = pc_q;
      tag_d         = epoch_q;
    end
    if (flush) begin
      pc_d    = redirect_pc;
      epoch_d = ~epoch_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      tag_q         <= 1'b0;
      epoch_q       <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      tag_q         <= tag_d;
      epoch_q       <= epoch_d;
    end
  end

`ifdef FETCH_HALT_DETECT_EN
  logic halted_q, halted_d;

  // a jump to its own address that decode has taken marks end of program
  always_comb begin
    halted_d = halted_q;
    if (accept && is_jump(dec.dec_instr) && (dec.dec_instr[ADDR_W-1:0] == dec.dec_pc))
      halted_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) halted_q <= 1'b0;
    else          halted_q <= halted_d;
  end

  assign halt_w = halted_q;
`else
  assign halt_w = 1'b0;
`endif

  assign halted = halt_w;

  fetch_skid_buf #(.ADDR_W(ADDR_W)) u_buf (
    .clock        (clock),
    .reset_n      (reset_n),
    .flush_i      (flush),
    .push_i       (push),
    .push_instr_i (q_imem),
    .push_pc_i    (inflight_pc_q),
    .pop_i        (accept),
    .head_instr_o (dec.dec_instr),
    .head_pc_o    (dec.dec_pc),
    .count_o      (count)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;
  localparam int AW = 12;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] address_imem;
  logic [31:0]   q_imem;
  logic          halted;
  logic          loop_en;
  int            n_cmp = 0;
  int            n_bad = 0;

  fetch_stage_if #(.ADDR_W(AW)) dec ();

  fetch_stage #(.ADDR_W(AW), .RESET_PC(12'h000)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .address_imem   (address_imem),
    .q_imem         (q_imem),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec            (dec),
    .halted         (halted)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] imem_word(input logic [AW-1:0] a);
    if (loop_en && a == 12'd24) return {5'b00001, 27'd24};
    return 32'h100 + {20'd0, a};
  endfunction

  always @(posedge clock) q_imem <= imem_word(address_imem);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      n_cmp++;
      assert (dut.u_buf.count_q <= 2'd2)
      else begin
        n_bad++;
        $error("FAIL buf_overflow: observed %0d expected <=2", dut.u_buf.count_q);
      end
    end
  end

  initial begin
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    loop_en        = 1'b0;
    dec.dec_ready  = 1'b1;
    tick(); tick();
    chk("rst_valid",  32'(dec.dec_valid), 32'd0);
    chk("rst_instr",  dec.dec_instr, 32'd0);
    chk("rst_pc",     32'(dec.dec_pc), 32'd0);
    chk("rst_pc1",    32'(dec.dec_pc_plus1), 32'd1);
    chk("rst_addr",   32'(address_imem), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);

    // streaming from reset
    reset_n = 1'b1;
    tick();
    chk("lat_valid_c1", 32'(dec.dec_valid), 32'd0);
    chk("lat_addr_c1",  32'(address_imem), 32'd1);
    tick();
    chk("lat_valid_c2", 32'(dec.dec_valid), 32'd1);
    chk("s_pc0",        32'(dec.dec_pc), 32'd0);
    chk("s_instr0",     dec.dec_instr, 32'h100);
    chk("s_pc1_0",      32'(dec.dec_pc_plus1), 32'd1);
    tick();
    chk("s_pc1",        32'(dec.dec_pc), 32'd1);
    tick();
    chk("s_pc2",        32'(dec.dec_pc), 32'd2);
    chk("s_instr2",     dec.dec_instr, 32'h102);
    tick();
    chk("s_pc3",        32'(dec.dec_pc), 32'd3);
    chk("s_cnt_steady", 32'(dut.u_buf.count_q), 32'd1);

    // decode stall
    dec.dec_ready = 1'b0;
    tick();
    chk("st_pc_a",   32'(dec.dec_pc), 32'd3);
    chk("st_cnt_a",  32'(dut.u_buf.count_q), 32'd2);
    chk("st_addr_a", 32'(address_imem), 32'd5);
    tick(); tick();
    chk("st_pc_b",    32'(dec.dec_pc), 32'd3);
    chk("st_instr_b", dec.dec_instr, 32'h103);
    chk("st_cnt_b",   32'(dut.u_buf.count_q), 32'd2);
    chk("st_addr_b",  32'(address_imem), 32'd5);
    dec.dec_ready = 1'b1;
    tick();
    chk("rs_pc4",   32'(dec.dec_pc), 32'd4);
    chk("rs_addr",  32'(address_imem), 32'd6);
    tick();
    chk("rs_pc5",   32'(dec.dec_pc), 32'd5);
    tick();
    chk("rs_pc6",   32'(dec.dec_pc), 32'd6);
    chk("rs_addr8", 32'(address_imem), 32'd8);

    // redirect with full buffer and simultaneous accept
    dec.dec_ready = 1'b0;
    tick();
    chk("rd_cnt_full", 32'(dut.u_buf.count_q), 32'd2);
    chk("rd_pc_head",  32'(dec.dec_pc), 32'd6);
    dec.dec_ready  = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 12'h040;
    tick();
    redirect_valid = 1'b0;
    chk("rd_valid_a", 32'(dec.dec_valid), 32'd0);
    chk("rd_addr_a",  32'(address_imem), 32'h040);
    chk("rd_cnt_a",   32'(dut.u_buf.count_q), 32'd0);
    tick();
    chk("rd_valid_b", 32'(dec.dec_valid), 32'd0);
    chk("rd_addr_b",  32'(address_imem), 32'h041);
    tick();
    chk("rd_valid_c", 32'(dec.dec_valid), 32'd1);
    chk("rd_pc_tgt",  32'(dec.dec_pc), 32'h040);
    chk("rd_instr",   dec.dec_instr, 32'h140);

    // redirect with a word in flight, then wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 12'hFFE;
    tick();
    redirect_valid = 1'b0;
    chk("wr_valid_a", 32'(dec.dec_valid), 32'd0);
    chk("wr_addr_a",  32'(address_imem), 32'hFFE);
    tick();
    chk("wr_valid_b", 32'(dec.dec_valid), 32'd0);
    tick();
    chk("wr_pc_ffe",  32'(dec.dec_pc), 32'hFFE);
    chk("wr_pc1_ffe", 32'(dec.dec_pc_plus1), 32'hFFF);
    tick();
    chk("wr_pc_fff",  32'(dec.dec_pc), 32'hFFF);
    chk("wr_in_fff",  dec.dec_instr, 32'h10FF);
    chk("wr_pc1_fff", 32'(dec.dec_pc_plus1), 32'h000);
    tick();
    chk("wr_pc_000",  32'(dec.dec_pc), 32'h000);
    chk("wr_in_000",  dec.dec_instr, 32'h100);
    tick();
    chk("wr_pc_001",  32'(dec.dec_pc), 32'h001);

    // asynchronous reset between edges
    #2 reset_n = 1'b0;
    #1;
    chk("ar_valid", 32'(dec.dec_valid), 32'd0);
    chk("ar_instr", dec.dec_instr, 32'd0);
    chk("ar_pc",    32'(dec.dec_pc), 32'd0);
    chk("ar_pc1",   32'(dec.dec_pc_plus1), 32'd1);
    chk("ar_addr",  32'(address_imem), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("ar_addr_c1", 32'(address_imem), 32'd1);
    chk("ar_valid_c1", 32'(dec.dec_valid), 32'd0);
    tick();
    chk("ar_pc_c2",   32'(dec.dec_pc), 32'd0);
    chk("ar_in_c2",   dec.dec_instr, 32'h100);

    // self-loop at address 24
    loop_en        = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 12'd22;
    tick();
    redirect_valid = 1'b0;
    chk("hl_addr_r0", 32'(address_imem), 32'd22);
    tick(); tick(); tick(); tick();
    chk("hl_pc24",    32'(dec.dec_pc), 32'd24);
    chk("hl_in24",    dec.dec_instr, 32'h0800_0018);
    chk("hl_pre",     32'(halted), 32'd0);
    tick();
    chk("hl_addr_r5", 32'(address_imem), 32'd27);
`ifdef FETCH_HALT_DETECT_EN
    chk("hl_set",     32'(halted), 32'd1);
`else
    chk("hl_off",     32'(halted), 32'd0);
    chk("hl_pc25",    32'(dec.dec_pc), 32'd25);
`endif
    tick(); tick();
`ifdef FETCH_HALT_DETECT_EN
    chk("hl_frozen",  32'(address_imem), 32'd27);
`else
    chk("hl_running", 32'(address_imem), 32'd29);
`endif
    redirect_valid = 1'b1;
    redirect_pc    = 12'h040;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_HALT_DETECT_EN
    chk("hl_rd_ign",  32'(address_imem), 32'd27);
    chk("hl_sticky",  32'(halted), 32'd1);
`else
    chk("hl_rd_ok",   32'(address_imem), 32'h040);
    chk("hl_never",   32'(halted), 32'd0);
`endif
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
